// File: rtl/sb_pkg.sv
// Shared types and default geometry for the MEM-stage store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sb_pkg;

  localparam int SB_DATA_W = 32;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DEPTH  = 4;
  localparam int SB_BE_W   = SB_DATA_W / 8;

  // One buffered store at the default geometry.
  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   be;
  } sb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_age_match.sv
// Picks the youngest entry whose valid and match bits are both set, walking head -> tail.
// Latency: combinational.
// Backpressure: none.
// Ports: valid/match per-entry vectors, head = oldest index; found + idx of youngest match.
module sb_age_match #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0]         match,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] pos;

  // Valid entries are contiguous from head, so scanning in age order and
  // letting the last hit win yields the youngest match. DEPTH is a power of
  // two, so the pointer add wraps naturally.
  always_comb begin
    found = 1'b0;
    idx   = head;
    pos   = head;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (valid[pos] && match[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer_fifo.sv
// Store buffer between MEM and D-cache: buffers byte-enabled stores, forwards to loads, drains oldest-first.
// Latency: store visible to lookup one cycle after acceptance; lookup is same-cycle; drain starts the cycle after threshold/flush.
// Backpressure: st_ready drops when full (registered count); cache_wr_* held stable while cache_wr_ready is low.
// Ports: st_* store in, ld_* lookup (hit/conflict/data), flush pulse, cache_wr_* drain handshake,
//        sb_stall/sb_empty/sb_count status. Optional SB_COALESCE_EN merges a store into the youngest entry.
module store_buffer_fifo
  import sb_pkg::*;
#(
  parameter int DATA_W       = SB_DATA_W,
  parameter int ADDR_W       = SB_ADDR_W,
  parameter int DEPTH        = SB_DEPTH,
  parameter int DRAIN_THRESH = DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [DATA_W/8-1:0]        st_be,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W/8-1:0]        ld_be,
  output logic                       ld_hit,
  output logic                       ld_conflict,
  output logic [DATA_W-1:0]          ld_data,
  input  logic                       flush,
  output logic                       cache_wr_valid,
  output logic [ADDR_W-1:0]          cache_wr_addr,
  output logic [DATA_W-1:0]          cache_wr_data,
  output logic [DATA_W/8-1:0]        cache_wr_be,
  input  logic                       cache_wr_ready,
  output logic                       sb_stall,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH+1)-1:0] sb_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  vld_q;
  logic [WA_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, young_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  sb_state_e         state_q, state_d;

  logic [WA_W-1:0]   st_word, ld_word;
  logic [DEPTH-1:0]  ld_match;
  logic              ld_found;
  logic [PTR_W-1:0]  ld_idx;
  logic              full, push, pop, coalesce;
  logic              unused_addr_bits;

  assign st_word          = st_addr[ADDR_W-1:OFF_W];
  assign ld_word          = ld_addr[ADDR_W-1:OFF_W];
  assign unused_addr_bits = ^{st_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};
  assign young_idx        = tail_q - PTR_W'(1);

  // ---------------- load lookup ----------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ld_match[i] = (addr_q[i] == ld_word);
    end
  end

  sb_age_match #(.DEPTH(DEPTH)) u_ld_age (
    .valid (vld_q),
    .match (ld_match),
    .head  (head_q),
    .found (ld_found),
    .idx   (ld_idx)
  );

  // Only the youngest match matters: an older entry covering more bytes is
  // stale for the bytes the youngest one wrote.
  always_comb begin
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    if (ld_valid && ld_found) begin
      if ((be_q[ld_idx] & ld_be) == ld_be) begin
        ld_hit  = 1'b1;
        ld_data = data_q[ld_idx];
      end else begin
        ld_conflict = 1'b1;
      end
    end
  end

  // ---------------- store acceptance ----------------
  assign full = (cnt_q == CNT_W'(DEPTH));

`ifdef SB_COALESCE_EN
  // Merge into the youngest entry unless it is the head currently being
  // presented to the cache (its contents must stay stable).
  assign coalesce = st_valid && (cnt_q != '0) && vld_q[young_idx] &&
                    (addr_q[young_idx] == st_word) &&
                    !(cache_wr_valid && (young_idx == head_q));
`else
  assign coalesce = 1'b0;
`endif

  assign st_ready = !full || coalesce;
  assign sb_stall = st_valid && !st_ready;
  assign push     = st_valid && st_ready && !coalesce;
  assign pop      = cache_wr_valid && cache_wr_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (cnt_d == '0)                  flush_pend_d = 1'b0;
    else if (flush && cnt_q != '0)    flush_pend_d = 1'b1;
  end

  // ---------------- drain FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0 && (cnt_q >= CNT_W'(DRAIN_THRESH) || flush_pend_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (cnt_d == '0 ||
                    ((cnt_q - CNT_W'(1)) < CNT_W'(DRAIN_THRESH) && !flush_pend_q))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cache_wr_valid = (state_q == DRAIN);
  assign cache_wr_addr  = cache_wr_valid ? {addr_q[head_q], {OFF_W{1'b0}}} : '0;
  assign cache_wr_data  = cache_wr_valid ? data_q[head_q] : '0;
  assign cache_wr_be    = cache_wr_valid ? be_q[head_q]   : '0;
  assign sb_empty       = (cnt_q == '0);
  assign sb_count       = cnt_q;

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= st_word;
        data_q[tail_q] <= st_data;
        be_q[tail_q]   <= st_be;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (coalesce) begin
        for (int b = 0; b < BE_W; b++) begin
          if (st_be[b]) data_q[young_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
        be_q[young_idx] <= be_q[young_idx] | st_be;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Directed bench for store_buffer_fifo at default geometry (32b data, 4 entries, drain threshold 4).
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1+ units later.
// Backpressure: cache_wr_ready driven explicitly per step.
module tb_store_buffer_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_hit;
  logic        ld_conflict;
  logic [31:0] ld_data;
  logic        flush;
  logic        cache_wr_valid;
  logic [31:0] cache_wr_addr;
  logic [31:0] cache_wr_data;
  logic [3:0]  cache_wr_be;
  logic        cache_wr_ready;
  logic        sb_stall;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int nchecks = 0;
  int nerrs   = 0;

  always #5 clk = ~clk;

  store_buffer_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .st_valid       (st_valid),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_be          (st_be),
    .st_ready       (st_ready),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_be          (ld_be),
    .ld_hit         (ld_hit),
    .ld_conflict    (ld_conflict),
    .ld_data        (ld_data),
    .flush          (flush),
    .cache_wr_valid (cache_wr_valid),
    .cache_wr_addr  (cache_wr_addr),
    .cache_wr_data  (cache_wr_data),
    .cache_wr_be    (cache_wr_be),
    .cache_wr_ready (cache_wr_ready),
    .sb_stall       (sb_stall),
    .sb_empty       (sb_empty),
    .sb_count       (sb_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    step();
    st_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
    flush = 1'b0; cache_wr_ready = 1'b0;

    // Reset state
    #3;
    check("rst_empty",    sb_empty, 1);
    check("rst_st_ready", st_ready, 1);
    check("rst_count",    sb_count, 0);
    check("rst_wr_valid", cache_wr_valid, 0);
    check("rst_wr_addr",  cache_wr_addr, 0);
    step();
    rst = 1'b0;

    // Fill to threshold: drain begins the cycle after count reaches 4
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4*i), 32'hD0 + 32'(i), 4'hF);
    #1;
    check("fill_count",    sb_count, 4);
    check("fill_st_ready", st_ready, 0);
    check("fill_wr_valid_pre", cache_wr_valid, 0);
    step();
    check("drain_wr_valid", cache_wr_valid, 1);
    check("drain_wr_addr",  cache_wr_addr, 32'h100);
    check("drain_wr_data",  cache_wr_data, 32'hD0);
    check("drain_wr_be",    cache_wr_be, 4'hF);

    // Cache not ready for 5 cycles while a store is blocked
    st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h55; st_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_stall",   sb_stall, 1);
      check("hold_wr_addr", cache_wr_addr, 32'h100);
      check("hold_wr_data", cache_wr_data, 32'hD0);
      step();
    end
    st_valid = 1'b0;
    cache_wr_ready = 1'b1;
    step();
    cache_wr_ready = 1'b0;
    #1;
    check("pop_count",    sb_count, 3);
    check("pop_st_ready", st_ready, 1);
    check("pop_idle",     cache_wr_valid, 0);

    // Forwarding ignores byte offset bits
    ld_valid = 1'b1; ld_addr = 32'h10A; ld_be = 4'hF;
    #1;
    check("fwd_108_hit",  ld_hit, 1);
    check("fwd_108_data", ld_data, 32'hD2);
    ld_valid = 1'b0;

    // Flush drains the remaining three in order
    flush = 1'b1;
    step();
    flush = 1'b0;
    cache_wr_ready = 1'b1;
    step();
    check("flush3_a", cache_wr_addr, 32'h104);
    step();
    check("flush3_b", cache_wr_addr, 32'h108);
    step();
    check("flush3_c", cache_wr_addr, 32'h10C);
    step();
    check("flush3_empty", sb_empty, 1);
    check("flush3_idle",  cache_wr_valid, 0);
    cache_wr_ready = 1'b0;

    // No same-cycle bypass, visible next cycle
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hAABBCCDD; st_be = 4'hF;
    ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'hF;
    #1;
    check("nobypass_hit", ld_hit, 0);
    step();
    st_valid = 1'b0;
    #1;
    check("fwd_200_hit",  ld_hit, 1);
    check("fwd_200_data", ld_data, 32'hAABBCCDD);
    ld_valid = 1'b0;

    // Partial cover
    store(32'h300, 32'h11, 4'h1);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_be = 4'hF;
    #1;
    check("part_conflict", ld_conflict, 1);
    check("part_hit",      ld_hit, 0);
    check("part_data",     ld_data, 0);
    ld_be = 4'h1;
    #1;
    check("byte_hit",  ld_hit, 1);
    check("byte_data", ld_data, 32'h11);
    ld_addr = 32'h400; ld_be = 4'hF;
    #1;
    check("miss_hit",      ld_hit, 0);
    check("miss_conflict", ld_conflict, 0);
    ld_valid = 1'b0; ld_addr = 32'h300;
    #1;
    check("ldoff_hit", ld_hit, 0);
    check("ldoff_conflict", ld_conflict, 0);
    check("two_count", sb_count, 2);

    // Flush with two entries
    flush = 1'b1; cache_wr_ready = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("flush2_a_valid", cache_wr_valid, 1);
    check("flush2_a_addr",  cache_wr_addr, 32'h200);
    step();
    check("flush2_b_addr",  cache_wr_addr, 32'h300);
    check("flush2_b_be",    cache_wr_be, 4'h1);
    step();
    check("flush2_empty", sb_empty, 1);
    check("flush2_idle",  cache_wr_valid, 0);
    cache_wr_ready = 1'b0;

    // Reset mid-drain abandons the presented entry
    store(32'h600, 32'h66, 4'hF);
    store(32'h604, 32'h67, 4'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("mid_wr_valid", cache_wr_valid, 1);
    check("mid_wr_addr",  cache_wr_addr, 32'h600);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_empty", sb_empty, 1);
    check("mid_rst_valid", cache_wr_valid, 0);
    check("mid_rst_count", sb_count, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_empty", sb_empty, 1);
    check("post_rst_valid", cache_wr_valid, 0);

    // Same word stored twice with disjoint byte enables
    store(32'h400, 32'h00005566, 4'h3);
    store(32'h400, 32'h77880000, 4'hC);
    ld_valid = 1'b1; ld_addr = 32'h400; ld_be = 4'hF;
    #1;
`ifdef SB_COALESCE_EN
    check("coal_count", sb_count, 1);
    check("coal_full_hit",  ld_hit, 1);
    check("coal_full_data", ld_data, 32'h77885566);
`else
    check("dup_count", sb_count, 2);
    check("dup_full_conflict", ld_conflict, 1);
    check("dup_full_hit",      ld_hit, 0);
`endif
    ld_be = 4'hC;
    #1;
    check("dup_hi_hit", ld_hit, 1);
`ifdef SB_COALESCE_EN
    check("coal_hi_data", ld_data, 32'h77885566);
`else
    check("dup_hi_data", ld_data, 32'h77880000);
`endif
    ld_be = 4'h3;
    #1;
`ifdef SB_COALESCE_EN
    check("coal_lo_hit", ld_hit, 1);
`else
    check("dup_lo_conflict", ld_conflict, 1);
`endif
    ld_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
